// File: rtl/eae_master.sv
// EAE master sequencer: decodes group-3 MQ/EAE operate words, runs MUY/DVI through
// an external EAE slave with a bounded WAIT, and issues a one-cycle writeback.
`timescale 1ns/1ps
module eae_master #(
  parameter int TIMEOUT_CYC = 48
) (
  input  logic        clock,
  input  logic        resetN,
  input  logic        instr_valid,
  input  logic [11:0] instr,
  input  logic [11:0] ac_in,
  input  logic [11:0] mq_in,
  input  logic        link_in,
  output logic        operand_req,
  input  logic        operand_valid,
  input  logic [11:0] operand,
  output logic        eae_start,
  output logic        eae_div,
  output logic [11:0] eae_ac,
  output logic [11:0] eae_mq,
  output logic [11:0] eae_operand,
  input  logic        eae_finished,
  input  logic [11:0] res_ac,
  input  logic [11:0] res_mq,
  input  logic        res_link,
  output logic        wb_valid,
  output logic [11:0] ac_out,
  output logic [11:0] mq_out,
  output logic        link_out,
  output logic        busy,
  output logic        timeout_err
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    START = 3'd2,
    WAIT  = 3'd3,
    WB    = 3'd4
  } state_t;

  localparam logic [11:0] OP_MUY = 12'o7405;
  localparam logic [11:0] OP_DVI = 12'o7407;
  localparam logic [11:0] OP_MQL = 12'o7421;
  localparam logic [11:0] OP_MQA = 12'o7501;
  localparam logic [11:0] OP_SWP = 12'o7521;
  localparam logic [11:0] OP_CLA = 12'o7601;
  localparam logic [5:0]  TO_LIM = 6'(TIMEOUT_CYC);

  state_t      r_state;
  state_t      w_next;
  logic [5:0]  r_cnt;
  logic [5:0]  w_cnt_inc;
  logic        w_timeout;
  logic        w_dec_arith;
  logic        w_dec_div;
  logic        w_dec_simple;
  logic [11:0] w_dec_ac;
  logic [11:0] w_dec_mq;
  logic        w_dec_link;
  logic        w_accept_arith;
  logic        w_accept_simple;
  logic        w_finish;

  logic        r_busy;
  logic        r_operand_req;
  logic        r_eae_start;
  logic        r_wb_valid;
  logic        r_timeout_err;
  logic        r_eae_div;
  logic [11:0] r_eae_ac;
  logic [11:0] r_eae_mq;
  logic [11:0] r_eae_operand;
  logic        r_link_snap;
  logic [11:0] r_ac_out;
  logic [11:0] r_mq_out;
  logic        r_link_out;

  assign w_cnt_inc       = r_cnt + 6'd1;
  assign w_accept_arith  = (r_state == IDLE) && instr_valid && w_dec_arith;
  assign w_accept_simple = (r_state == IDLE) && instr_valid && w_dec_simple;
  assign w_finish        = (r_state == WAIT) && eae_finished;

  // Opcode decode and the writeback values of the register-only operations
  always_comb begin
    w_dec_arith  = 1'b0;
    w_dec_div    = 1'b0;
    w_dec_simple = 1'b0;
    w_dec_ac     = ac_in;
    w_dec_mq     = mq_in;
    w_dec_link   = link_in;
    case (instr)
      OP_MUY: w_dec_arith = 1'b1;
      OP_DVI: begin
        w_dec_arith = 1'b1;
        w_dec_div   = 1'b1;
      end
      OP_MQL: begin
        w_dec_simple = 1'b1;
        w_dec_ac     = 12'o0000;
        w_dec_mq     = ac_in;
      end
      OP_MQA: begin
        w_dec_simple = 1'b1;
        w_dec_ac     = ac_in | mq_in;
      end
      OP_SWP: begin
        w_dec_simple = 1'b1;
        w_dec_ac     = mq_in;
        w_dec_mq     = ac_in;
      end
      OP_CLA: begin
        w_dec_simple = 1'b1;
        w_dec_ac     = 12'o0000;
      end
      default: w_dec_arith = 1'b0;
    endcase
  end

  // Next-state logic; a finish on the last allowed WAIT cycle beats the timeout
  always_comb begin
    w_next    = r_state;
    w_timeout = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept_arith) w_next = FETCH;
        else if (w_accept_simple) w_next = WB;
        else w_next = IDLE;
      end
      FETCH: begin
        if (operand_valid) w_next = START;
        else w_next = FETCH;
      end
      START: w_next = WAIT;
      WAIT: begin
        if (eae_finished) begin
          w_next = WB;
        end else if (w_cnt_inc == TO_LIM) begin
          w_next    = WB;
          w_timeout = 1'b1;
        end else begin
          w_next = WAIT;
        end
      end
      WB:      w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State register, handshake strobes, WAIT counter and sticky timeout flag
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_state       <= IDLE;
      r_busy        <= 1'b0;
      r_operand_req <= 1'b0;
      r_eae_start   <= 1'b0;
      r_wb_valid    <= 1'b0;
      r_cnt         <= 6'd0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state       <= w_next;
      r_busy        <= (w_next != IDLE);
      r_operand_req <= (w_next == FETCH);
      r_eae_start   <= (w_next == START);
      r_wb_valid    <= (r_state == WB);
      if (r_state == START) r_cnt <= 6'd0;
      else if (r_state == WAIT) r_cnt <= w_cnt_inc;
      else r_cnt <= r_cnt;
      r_timeout_err <= r_timeout_err | w_timeout;
    end
  end

  // Operand snapshots feeding the EAE and the writeback result registers
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_eae_div     <= 1'b0;
      r_eae_ac      <= 12'o0000;
      r_eae_mq      <= 12'o0000;
      r_link_snap   <= 1'b0;
      r_eae_operand <= 12'o0000;
      r_ac_out      <= 12'o0000;
      r_mq_out      <= 12'o0000;
      r_link_out    <= 1'b0;
    end else begin
      if (w_accept_arith) begin
        r_eae_div   <= w_dec_div;
        r_eae_ac    <= ac_in;
        r_eae_mq    <= mq_in;
        r_link_snap <= link_in;
      end
      if ((r_state == FETCH) && operand_valid) r_eae_operand <= operand;
      if (w_accept_simple) begin
        r_ac_out   <= w_dec_ac;
        r_mq_out   <= w_dec_mq;
        r_link_out <= w_dec_link;
      end else if (w_finish) begin
        r_ac_out   <= res_ac;
        r_mq_out   <= res_mq;
        r_link_out <= res_link;
      end else if (w_timeout) begin
        r_ac_out   <= r_eae_ac;
        r_mq_out   <= r_eae_mq;
        r_link_out <= r_link_snap;
      end
    end
  end

  assign operand_req = r_operand_req;
  assign eae_start   = r_eae_start;
  assign eae_div     = r_eae_div;
  assign eae_ac      = r_eae_ac;
  assign eae_mq      = r_eae_mq;
  assign eae_operand = r_eae_operand;
  assign wb_valid    = r_wb_valid;
  assign ac_out      = r_ac_out;
  assign mq_out      = r_mq_out;
  assign link_out    = r_link_out;
  assign busy        = r_busy;
  assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_eae_master.sv
// Directed bench for eae_master: writeback results go through a scoreboard queue;
// a small EAE slave model answers eae_start after a programmable delay.
`timescale 1ns/1ps
module tb_eae_master;

  logic        clock;
  logic        resetN;
  logic        instr_valid;
  logic [11:0] instr;
  logic [11:0] ac_in;
  logic [11:0] mq_in;
  logic        link_in;
  logic        operand_req;
  logic        operand_valid;
  logic [11:0] operand;
  logic        eae_start;
  logic        eae_div;
  logic [11:0] eae_ac;
  logic [11:0] eae_mq;
  logic [11:0] eae_operand;
  logic        eae_finished;
  logic [11:0] res_ac;
  logic [11:0] res_mq;
  logic        res_link;
  logic        wb_valid;
  logic [11:0] ac_out;
  logic [11:0] mq_out;
  logic        link_out;
  logic        busy;
  logic        timeout_err;

  typedef struct {
    logic [11:0] ac;
    logic [11:0] mq;
    logic        link;
  } wb_t;

  wb_t  sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   n_cyc = 0;
  int   start_cyc = -1;
  int   wb_cyc = 0;
  int   fin_dly = 0;
  int   wb_cnt = 0;
  int   start_cnt = 0;
  int   to_cyc = -1;
  int   w0 = 0;
  int   s0 = 0;
  logic wb_flag = 1'b0;
  logic start_flag = 1'b0;

  localparam logic [11:0] OP_MUY = 12'o7405;
  localparam logic [11:0] OP_DVI = 12'o7407;
  localparam logic [11:0] OP_MQL = 12'o7421;
  localparam logic [11:0] OP_MQA = 12'o7501;
  localparam logic [11:0] OP_SWP = 12'o7521;
  localparam logic [11:0] OP_CLA = 12'o7601;

  eae_master #(.TIMEOUT_CYC(48)) dut (
    .clock(clock), .resetN(resetN), .instr_valid(instr_valid), .instr(instr),
    .ac_in(ac_in), .mq_in(mq_in), .link_in(link_in), .operand_req(operand_req),
    .operand_valid(operand_valid), .operand(operand), .eae_start(eae_start),
    .eae_div(eae_div), .eae_ac(eae_ac), .eae_mq(eae_mq), .eae_operand(eae_operand),
    .eae_finished(eae_finished), .res_ac(res_ac), .res_mq(res_mq), .res_link(res_link),
    .wb_valid(wb_valid), .ac_out(ac_out), .mq_out(mq_out), .link_out(link_out),
    .busy(busy), .timeout_err(timeout_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0o expected %0o", tag, obs, exp);
    end
  endtask

  // One clock: sample on the falling edge, pop the scoreboard, play the EAE slave.
  task automatic step();
    wb_t e;
    @(negedge clock);
    cyc++;
    chk("start_wb_overlap", 32'(eae_start & wb_valid), 32'd0);
    if (wb_valid === 1'b1) begin
      wb_cnt++;
      wb_cyc  = cyc;
      wb_flag = 1'b1;
      if (sb_q.size() == 0) begin
        chk("sb_depth", 32'(sb_q.size()), 32'd1);
      end else begin
        e = sb_q.pop_front();
        chk("wb_ac", 32'(ac_out), 32'(e.ac));
        chk("wb_mq", 32'(mq_out), 32'(e.mq));
        chk("wb_link", 32'(link_out), 32'(e.link));
      end
    end
    if (eae_start === 1'b1) begin
      start_cnt++;
      start_cyc  = cyc;
      start_flag = 1'b1;
    end
    eae_finished = (start_cyc >= 0 && fin_dly > 0 && cyc == start_cyc + fin_dly) ? 1'b1 : 1'b0;
  endtask

  task automatic issue(input logic [11:0] op, input logic [11:0] a, input logic [11:0] m,
                       input logic l);
    step();
    instr = op; ac_in = a; mq_in = m; link_in = l; instr_valid = 1'b1;
    n_cyc = cyc; wb_flag = 1'b0; start_flag = 1'b0; start_cyc = -1;
    step();
    instr_valid = 1'b0; instr = 12'o0000;
    ac_in = 12'o7070; mq_in = 12'o0707; link_in = ~l;
  endtask

  task automatic wait_wb(input int budget);
    for (int k = 0; k < budget && !wb_flag; k++) step();
    chk("wb_seen", 32'(wb_flag), 32'd1);
  endtask

  task automatic wait_start(input int budget);
    for (int k = 0; k < budget && !start_flag; k++) step();
    chk("start_seen", 32'(start_flag), 32'd1);
  endtask

  task automatic simple_op(input logic [11:0] op, input logic [11:0] a, input logic [11:0] m,
                           input logic l, input logic [11:0] ea, input logic [11:0] em,
                           input logic el);
    sb_q.push_back('{ac: ea, mq: em, link: el});
    issue(op, a, m, l);
    wait_wb(6);
    chk("simple_wb_latency", 32'(wb_cyc - n_cyc), 32'd2);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_wb_valid"}, 32'(wb_valid), 32'd0);
    chk({tag, "_eae_start"}, 32'(eae_start), 32'd0);
    chk({tag, "_operand_req"}, 32'(operand_req), 32'd0);
    chk({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
    chk({tag, "_eae_div"}, 32'(eae_div), 32'd0);
    chk({tag, "_eae_ac"}, 32'(eae_ac), 32'd0);
    chk({tag, "_eae_mq"}, 32'(eae_mq), 32'd0);
    chk({tag, "_eae_operand"}, 32'(eae_operand), 32'd0);
    chk({tag, "_ac_out"}, 32'(ac_out), 32'd0);
    chk({tag, "_mq_out"}, 32'(mq_out), 32'd0);
    chk({tag, "_link_out"}, 32'(link_out), 32'd0);
  endtask

  initial begin
    resetN = 1'b0; instr_valid = 1'b0; instr = 12'o0000; ac_in = 12'o0000; mq_in = 12'o0000;
    link_in = 1'b0; operand_valid = 1'b0; operand = 12'o0000; eae_finished = 1'b0;
    res_ac = 12'o0000; res_mq = 12'o0000; res_link = 1'b0;

    step();
    chk_all_zero("reset");
    resetN = 1'b1;
    step();

    simple_op(OP_SWP, 12'o1234, 12'o4321, 1'b1, 12'o4321, 12'o1234, 1'b1);
    simple_op(OP_MQL, 12'o5670, 12'o1111, 1'b0, 12'o0000, 12'o5670, 1'b0);
    simple_op(OP_MQA, 12'o1200, 12'o0034, 1'b1, 12'o1234, 12'o0034, 1'b1);
    simple_op(OP_CLA, 12'o7777, 12'o2525, 1'b0, 12'o0000, 12'o2525, 1'b0);

    w0 = wb_cnt;
    issue(12'o7000, 12'o0001, 12'o0002, 1'b0);
    chk("noop_busy", 32'(busy), 32'd0);
    step(); step(); step();
    chk("noop_no_wb", 32'(wb_cnt - w0), 32'd0);

    // MUY with operand ready and a 5-cycle EAE
    operand_valid = 1'b1; operand = 12'o0003; fin_dly = 5;
    res_ac = 12'o0000; res_mq = 12'o0036; res_link = 1'b0;
    sb_q.push_back('{ac: 12'o0000, mq: 12'o0036, link: 1'b0});
    s0 = start_cnt;
    issue(OP_MUY, 12'o0000, 12'o0012, 1'b0);
    wait_start(6);
    chk("muy_start_latency", 32'(start_cyc - n_cyc), 32'd2);
    chk("muy_eae_div", 32'(eae_div), 32'd0);
    chk("muy_eae_mq", 32'(eae_mq), 32'o0012);
    chk("muy_eae_operand", 32'(eae_operand), 32'o0003);
    wait_wb(20);
    chk("muy_wb_latency", 32'(wb_cyc - start_cyc), 32'd7);
    chk("muy_start_count", 32'(start_cnt - s0), 32'd1);

    // DVI overflow; eae_div must hold through WAIT
    operand = 12'o0001; fin_dly = 3;
    res_ac = 12'o7777; res_mq = 12'o0000; res_link = 1'b1;
    sb_q.push_back('{ac: 12'o7777, mq: 12'o0000, link: 1'b1});
    issue(OP_DVI, 12'o7777, 12'o0000, 1'b0);
    wait_start(6);
    chk("dvi_eae_ac", 32'(eae_ac), 32'o7777);
    for (int k = 0; k < 20 && !wb_flag; k++) begin
      chk("dvi_div_hold", 32'(eae_div), 32'd1);
      step();
    end
    chk("dvi_wb_seen", 32'(wb_flag), 32'd1);

    // Finish on the 48th WAIT cycle wins over the timeout
    operand = 12'o0005; fin_dly = 48;
    res_ac = 12'o1234; res_mq = 12'o5670; res_link = 1'b1;
    sb_q.push_back('{ac: 12'o1234, mq: 12'o5670, link: 1'b1});
    issue(OP_MUY, 12'o0100, 12'o0200, 1'b0);
    wait_start(6);
    wait_wb(60);
    chk("edge_wb_latency", 32'(wb_cyc - start_cyc), 32'd50);
    chk("edge_no_timeout", 32'(timeout_err), 32'd0);

    // No finish at all: timeout, writeback of the snapshot
    fin_dly = 0; to_cyc = -1;
    sb_q.push_back('{ac: 12'o1111, mq: 12'o2222, link: 1'b1});
    issue(OP_MUY, 12'o1111, 12'o2222, 1'b1);
    wait_start(6);
    for (int k = 0; k < 70 && !wb_flag; k++) begin
      step();
      if (timeout_err === 1'b1 && to_cyc < 0) to_cyc = cyc;
    end
    chk("to_wb_seen", 32'(wb_flag), 32'd1);
    chk("to_err_cycle", 32'(to_cyc - start_cyc), 32'd49);
    chk("to_wb_latency", 32'(wb_cyc - start_cyc), 32'd50);
    simple_op(OP_SWP, 12'o0007, 12'o0070, 1'b0, 12'o0070, 12'o0007, 1'b0);
    chk("to_sticky", 32'(timeout_err), 32'd1);

    // Second instr during FETCH is ignored; operand held off 4 cycles
    operand_valid = 1'b0; operand = 12'o0002; fin_dly = 2;
    res_ac = 12'o0000; res_mq = 12'o0044; res_link = 1'b0;
    sb_q.push_back('{ac: 12'o0000, mq: 12'o0044, link: 1'b0});
    w0 = wb_cnt;
    issue(OP_MUY, 12'o0000, 12'o0022, 1'b0);
    chk("bi_req_1", 32'(operand_req), 32'd1);
    instr = OP_SWP; instr_valid = 1'b1; ac_in = 12'o1234; mq_in = 12'o4321;
    step();
    instr_valid = 1'b0;
    chk("bi_req_2", 32'(operand_req), 32'd1);
    step();
    chk("bi_req_3", 32'(operand_req), 32'd1);
    step();
    chk("bi_req_4", 32'(operand_req), 32'd1);
    step();
    operand_valid = 1'b1;
    wait_start(6);
    chk("bi_start_latency", 32'(start_cyc - n_cyc), 32'd6);
    chk("bi_eae_operand", 32'(eae_operand), 32'o0002);
    wait_wb(20);
    step(); step(); step(); step();
    chk("bi_single_wb", 32'(wb_cnt - w0), 32'd1);

    // Asynchronous reset in WAIT; the late EAE result must be dropped
    fin_dly = 8;
    res_ac = 12'o7777; res_mq = 12'o7777; res_link = 1'b1;
    issue(OP_MUY, 12'o0055, 12'o0066, 1'b1);
    wait_start(6);
    step(); step(); step();
    resetN = 1'b0;
    #1;
    chk_all_zero("rst_async");
    w0 = wb_cnt;
    step();
    resetN = 1'b1;
    for (int k = 0; k < 20; k++) step();
    chk("rst_no_wb", 32'(wb_cnt - w0), 32'd0);
    chk_all_zero("rst_after");

    simple_op(OP_SWP, 12'o3210, 12'o0123, 1'b1, 12'o0123, 12'o3210, 1'b1);
    chk("post_rst_timeout_clear", 32'(timeout_err), 32'd0);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
